// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with per-register pending (reserved) bits and a bulk clear sequencer.
// Latency: reads are combinational (0 cycles); writes, reserves and clear steps take effect at the next rising clk.
// Backpressure: while busy is high, write, reserve and clear requests are dropped rather than queued; reads stay live.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   we3, wa3, wd3          write enable / address / data
//   ra1, ra2 -> rd1, rd2   read ports, with pend1 / pend2 pending flags
//   rsv_en, rsv_addr       mark a register as pending (reserved, not yet written)
//   clr_req -> busy        start a bulk clear; busy covers the whole sequence
//   dbg_addr -> dbg_data   debug read of stored state, never forwarded
module rf_scoreboard #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             pend1,
    output logic             pend2,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             clr_req,
    output logic             busy,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam bit            BYP_EN   = (BYPASS != 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;

    logic             clr_act;
    logic             wr_ok;
    logic             rsv_ok;
    logic             byp1, byp2;

    // ------------------------------------------------------------------
    // Clear sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer: next state. Register 0 is hard-wired to zero, so
    // the walk starts at 1. Returning to IDLE for one cycle before a held
    // clr_req is re-sampled gives a one-cycle gap between back-to-back
    // sequences.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    idx_d   = FIRST_IDX;
                end
            end
            S_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + FIRST_IDX;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Clear sequencer: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        clr_act = 1'b0;
        if (state_q == S_CLEAR) begin
            busy    = 1'b1;
            clr_act = 1'b1;
        end
    end

    // Requests are only honoured when idle and outside reset; address 0
    // is never a legal target. Gating on rst also keeps forwarded write
    // data off the read ports while reset is asserted.
    assign wr_ok  = we3    && !busy && !rst && (wa3      != '0);
    assign rsv_ok = rsv_en && !busy && !rst && (rsv_addr != '0);

    // ------------------------------------------------------------------
    // Storage next state. The reserve is applied after the write so that
    // a same-cycle reserve + write to one register leaves it pending with
    // the new data.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (clr_act) begin
            regs_d[idx_q] = '0;
            pend_d[idx_q] = 1'b0;
        end else begin
            if (wr_ok) begin
                regs_d[wa3] = wd3;
                pend_d[wa3] = 1'b0;
            end
            if (rsv_ok) begin
                pend_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Forwarding makes an in-flight write visible in the same
    // cycle and also shows the register as no longer pending.
    // ------------------------------------------------------------------
    assign byp1 = BYP_EN && wr_ok && (ra1 == wa3);
    assign byp2 = BYP_EN && wr_ok && (ra2 == wa3);

    always_comb begin
        rd1      = '0;
        rd2      = '0;
        pend1    = 1'b0;
        pend2    = 1'b0;
        dbg_data = '0;

        if (byp1) begin
            rd1 = wd3;
        end else if (ra1 != '0) begin
            rd1   = regs_q[ra1];
            pend1 = pend_q[ra1];
        end

        if (byp2) begin
            rd2 = wd3;
        end else if (ra2 != '0) begin
            rd2   = regs_q[ra2];
            pend2 = pend_q[ra2];
        end

        if (dbg_addr != '0) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic [AW-1:0]    ra1, ra2;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             clr_req;
    logic [AW-1:0]    dbg_addr;

    logic [WIDTH-1:0] rd1, rd2, dbg_data;
    logic             pend1, pend2, busy;

    logic [WIDTH-1:0] rd1_nb, rd2_nb, dbg_nb;
    logic             pend1_nb, pend2_nb, busy_nb;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] fill [DEPTH];

    always #5 clk = ~clk;

    rf_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .pend1(pend1), .pend2(pend2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    rf_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .pend1(pend1_nb), .pend2(pend2_nb),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .busy(busy_nb),
        .dbg_addr(dbg_addr), .dbg_data(dbg_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        we3      = 1'b0;
        wa3      = '0;
        wd3      = '0;
        ra1      = '0;
        ra2      = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        clr_req  = 1'b0;
        dbg_addr = '0;
        for (int k = 0; k < DEPTH; k++) fill[k] = WIDTH'(8'h11 * k);

        // ---------------- reset state ----------------
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_rd1", rd1, 0);
        chk("rst_dbg", dbg_data, 0);
        #10;
        rst = 1'b0;
        #1;
        ra1 = 3'd3;
        #1;
        chk("post_rst_rd1", rd1, 0);
        chk("post_rst_pend1", pend1, 0);
        chk("post_rst_busy", busy, 0);

        // ---------------- basic write / read ----------------
        write_reg(3'd3, 8'hA5);
        ra1 = 3'd3;
        dbg_addr = 3'd3;
        #1;
        chk("wr3_rd1", rd1, 8'hA5);
        chk("wr3_pend1", pend1, 0);
        chk("wr3_dbg", dbg_data, 8'hA5);
        chk("wr3_rd1_nb", rd1_nb, 8'hA5);

        write_reg(3'd0, 8'hFF);
        ra2 = 3'd0;
        dbg_addr = 3'd0;
        #1;
        chk("wr0_rd2", rd2, 0);
        chk("wr0_dbg", dbg_data, 0);

        // ---------------- forwarding ----------------
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h3C; ra1 = 3'd5; ra2 = 3'd5; dbg_addr = 3'd5;
        #1;
        chk("byp_rd1", rd1, 8'h3C);
        chk("byp_rd2", rd2, 8'h3C);
        chk("nobyp_rd1", rd1_nb, 8'h00);
        chk("byp_dbg_stored", dbg_data, 8'h00);
        tick();
        we3 = 1'b0;
        #1;
        chk("byp_after_rd1", rd1, 8'h3C);
        chk("nobyp_after_rd1", rd1_nb, 8'h3C);

        // ---------------- reservation ----------------
        rsv_en = 1'b1; rsv_addr = 3'd2; ra1 = 3'd2;
        #1;
        chk("rsv_before_edge", pend1, 0);
        tick();
        rsv_en = 1'b0;
        #1;
        chk("rsv_pend1", pend1, 1);
        chk("rsv_pend1_nb", pend1_nb, 1);
        we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h77;
        #1;
        chk("rsv_byp_pend1", pend1, 0);
        chk("rsv_nobyp_pend1", pend1_nb, 1);
        chk("rsv_byp_rd1", rd1, 8'h77);
        tick();
        we3 = 1'b0;
        #1;
        chk("wr_clears_pend", pend1, 0);
        chk("wr_clears_rd1", rd1, 8'h77);
        we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h5A; rsv_en = 1'b1; rsv_addr = 3'd2;
        tick();
        we3 = 1'b0; rsv_en = 1'b0;
        #1;
        chk("rsv_wins_pend", pend1, 1);
        chk("rsv_wins_data", rd1, 8'h5A);
        rsv_en = 1'b1; rsv_addr = 3'd0; ra2 = 3'd0;
        tick();
        rsv_en = 1'b0;
        #1;
        chk("rsv0_pend2", pend2, 0);

        // ---------------- bulk clear ----------------
        for (int k = 1; k < DEPTH; k++) write_reg(AW'(k), fill[k]);
        rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        rsv_en = 1'b0;
        ra1 = 3'd4;
        #1;
        chk("pre_clr_pend4", pend1, 1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < DEPTH - 1; c++) begin
            chk($sformatf("clr_busy_c%0d", c), busy, 1);
            for (int k = 1; k < DEPTH; k++) begin
                dbg_addr = AW'(k);
                #1;
                chk($sformatf("clr_c%0d_r%0d", c, k), dbg_data, (k <= c) ? 0 : fill[k]);
            end
            if (c == 2) begin
                we3 = 1'b1; wa3 = 3'd7; wd3 = 8'hEE;
                rsv_en = 1'b1; rsv_addr = 3'd6;
                clr_req = 1'b1;
            end
            tick();
            we3 = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
        end
        chk("clr_done_busy", busy, 0);
        ra1 = 3'd7; ra2 = 3'd6; dbg_addr = 3'd4;
        #1;
        chk("clr_wr_ignored", rd1, 0);
        chk("clr_rsv_ignored", pend2, 0);
        chk("clr_reg4", dbg_data, 0);
        ra1 = 3'd4;
        #1;
        chk("clr_pend4", pend1, 0);
        tick();
        chk("clr_req_ignored", busy, 0);

        // ---------------- held clr_req restarts after one idle cycle ----------------
        clr_req = 1'b1;
        tick();
        for (int i = 0; i < DEPTH - 1; i++) begin
            chk($sformatf("held_busy_%0d", i), busy, 1);
            tick();
        end
        chk("held_gap", busy, 0);
        tick();
        chk("held_restart", busy, 1);
        clr_req = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        chk("held_end", busy, 0);

        // ---------------- async reset mid-clear ----------------
        for (int k = 1; k < DEPTH; k++) write_reg(AW'(k), fill[k]);
        ra1 = 3'd6; ra2 = 3'd7; dbg_addr = 3'd5;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_rd1", rd1, fill[6]);
        chk("mid_dbg5", dbg_data, fill[5]);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd1", rd1, 0);
        chk("arst_rd2", rd2, 0);
        chk("arst_dbg", dbg_data, 0);
        #1;
        rst = 1'b0;
        tick();
        chk("arst_idle", busy, 0);
        chk("arst_rd1_after", rd1, 0);
        write_reg(3'd6, 8'h42);
        #1;
        chk("arst_wr_ok", rd1, 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
